drum_voice_player: RTL and testbench

DRUM_VOICE_PLAYER -- requirements
Module: drum_voice_player

---
 rtl/drum_pkg.sv | 18 +
 rtl/drum_gain_mult.sv | 18 +
 rtl/drum_voice_player.sv | 97 +++++++++
 tb/tb_drum_voice_player.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// drum_pkg: shared FSM states, widths and gain-smoothing helper for the drum voice player.
package drum_pkg;
    localparam int GAIN_W      = 10;
    localparam int SAMPLE_W    = 16;
    localparam int GAIN_SHIFT  = 10;
    localparam int SMOOTH_STEP = 8;
    typedef enum logic [2:0] {IDLE, WAIT_TICK, READ, SCALE, EMIT} state_t;
    // Moves cur toward tgt by at most SMOOTH_STEP, landing exactly on tgt when close.
    function automatic logic [GAIN_W-1:0] smooth_toward(input logic [GAIN_W-1:0] cur,
                                                        input logic [GAIN_W-1:0] tgt);
        logic             up;
        logic [GAIN_W-1:0] diff;
        up   = tgt > cur;
        diff = up ? tgt - cur : cur - tgt;
        return (diff > GAIN_W'(SMOOTH_STEP)) ?
               (up ? cur + GAIN_W'(SMOOTH_STEP) : cur - GAIN_W'(SMOOTH_STEP)) : tgt;
    endfunction
endpackage

// File: rtl/drum_gain_mult.sv
// drum_gain_mult: registered signed sample x unsigned gain, arithmetic shift down to sample width.
module drum_gain_mult
    import drum_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_en,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic        [GAIN_W-1:0]   i_gain,
    output logic signed [SAMPLE_W-1:0] o_sample
);
    logic signed [SAMPLE_W+GAIN_W:0] w_prod;
    assign w_prod = i_sample * $signed({1'b0, i_gain});
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_sample <= '0;
        else if (i_en) o_sample <= SAMPLE_W'(w_prod >>> GAIN_SHIFT);
    end
endmodule

// File: rtl/drum_voice_player.sv
// drum_voice_player: tick-paced one-shot sample player with retrigger and gain scaling.
// Define DRUM_PLAYER_SMOOTH_EN to slew the applied gain toward the gain input.
module drum_voice_player
    import drum_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int SAMPLE_LEN = 8192
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       audio_tick,
    input  logic                       trigger,
    input  logic        [GAIN_W-1:0]   gain,
    output logic                       rom_rd,
    output logic        [ADDR_W-1:0]   rom_addr,
    input  logic signed [SAMPLE_W-1:0] rom_data,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       busy
);
    state_t            r_state, w_next;
    logic              r_trig_q, r_pend, r_busy;
    logic [ADDR_W-1:0] r_ptr;
    logic [GAIN_W-1:0] w_gain;
    logic              w_edge, w_tick, w_restart, w_last, w_to_idle;

    assign w_edge    = trigger & ~r_trig_q;
    assign w_tick    = audio_tick & (r_state == IDLE || r_state == WAIT_TICK);
    assign w_restart = w_tick & (r_pend | w_edge);
    assign w_last    = r_ptr == ADDR_W'(SAMPLE_LEN - 1);
    assign w_to_idle = (r_state == EMIT) & (~r_busy | (w_last & ~r_pend & ~w_edge));
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, WAIT_TICK: if (w_tick) w_next = READ;
            READ:            w_next = SCALE;
            SCALE:           w_next = EMIT;
            EMIT:            w_next = w_to_idle ? IDLE : WAIT_TICK;
            default:         w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_q     <= 1'b0;
            r_pend       <= 1'b0;
            r_busy       <= 1'b0;
            r_ptr        <= '0;
            rom_rd       <= 1'b0;
            rom_addr     <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_trig_q     <= trigger;
            r_pend       <= w_tick ? 1'b0 : (r_pend | w_edge);
            rom_rd       <= w_tick & (w_restart | r_busy);
            sample_valid <= r_state == SCALE;
            if (w_tick & (w_restart | r_busy)) rom_addr <= w_restart ? '0 : r_ptr;
            if (w_restart) r_ptr <= '0;
            else if ((r_state == EMIT) & r_busy & ~w_last) r_ptr <= r_ptr + 1'b1;
            if (w_restart) r_busy <= 1'b1;
            else if (w_to_idle) r_busy <= 1'b0;
        end
    end

`ifdef DRUM_PLAYER_SMOOTH_EN
    logic [GAIN_W-1:0] r_gain_eff;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_gain_eff <= '0;
        else if (w_tick) r_gain_eff <= smooth_toward(r_gain_eff, gain);
    end
    assign w_gain = r_gain_eff;
`else
    logic [GAIN_W-1:0] r_gain_smp;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_gain_smp <= '0;
        else if (w_tick) r_gain_smp <= gain;
    end
    assign w_gain = r_gain_smp;
`endif

    // Idle ticks (r_busy low) scale a forced zero so the output cadence never changes.
    drum_gain_mult u_mult (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (r_state == SCALE),
        .i_sample (r_busy ? rom_data : SAMPLE_W'(0)),
        .i_gain   (w_gain),
        .o_sample (sample_out)
    );
endmodule

// File: tb/tb_drum_voice_player.sv
// tb_drum_voice_player: directed and random ticks against a tick-level behavioural player model.
module tb_drum_voice_player;
    localparam int AW  = 4;
    localparam int LEN = 4;

    logic               clk = 0, reset_n = 0, audio_tick = 0, trigger = 0;
    logic        [9:0]  gain = 0;
    logic               rom_rd, sample_valid, busy;
    logic        [AW-1:0] rom_addr;
    logic signed [15:0] rom_data = 0, sample_out;
    logic signed [15:0] rom [16];

    int n_chk = 0, n_fail = 0;
    bit m_play, m_pend;
    int m_ptr, m_eff;
    logic signed [15:0] m_out;

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_rd ? rom[rom_addr] : 16'($urandom);

    drum_voice_player #(.ADDR_W(AW), .SAMPLE_LEN(LEN)) dut (
        .clk(clk), .reset_n(reset_n), .audio_tick(audio_tick), .trigger(trigger), .gain(gain),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scaled(input int d, input int g);
        int p = d * g;
        return p >= 0 ? p / 1024 : -((-p + 1023) / 1024);
    endfunction

    task automatic model_reset();
        m_play = 0; m_pend = 0; m_ptr = 0; m_eff = 0;
    endtask

    task automatic pulse();
        @(negedge clk); trigger = 1;
        @(negedge clk); trigger = 0;
        m_pend = 1;
    endtask

    task automatic do_tick(input bit same_trig = 0, input bit mid_trig = 0, input bit early2 = 0);
        bit rd;
        int addr, g, d;
        @(negedge clk);
        audio_tick = 1;
        if (same_trig) begin trigger = 1; m_pend = 1; end
        d = int'(gain) - m_eff;
        if (d > 8) d = 8;
        if (d < -8) d = -8;
        m_eff += d;
`ifdef DRUM_PLAYER_SMOOTH_EN
        g = m_eff;
`else
        g = gain;
`endif
        if (m_pend) begin m_play = 1; m_ptr = 0; m_pend = 0; end
        rd = m_play;
        addr = m_ptr;
        m_out = rd ? 16'(scaled(rom[addr], g)) : 16'sd0;
        @(negedge clk);
        audio_tick = 0;
        trigger = mid_trig;
        chk("rom_rd_t1", rom_rd, rd);
        if (rd) chk("rom_addr_t1", rom_addr, addr);
        chk("valid_t1", sample_valid, 0);
        chk("busy_t1", busy, m_play);
        if (mid_trig) m_pend = 1;
        @(negedge clk);
        trigger = 0;
        if (early2) audio_tick = 1;
        chk("rom_rd_t2", rom_rd, 0);
        chk("valid_t2", sample_valid, 0);
        @(negedge clk);
        audio_tick = 0;
        chk("valid_t3", sample_valid, 1);
        chk("sample_t3", sample_out, m_out);
        if (m_play) begin
            if (m_ptr == LEN - 1) begin if (!m_pend) m_play = 0; end
            else m_ptr++;
        end
        @(negedge clk);
        chk("valid_t4", sample_valid, 0);
        chk("hold_t4", sample_out, m_out);
        chk("busy_t4", busy, m_play);
        chk("rom_rd_t4", rom_rd, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_rd"}, rom_rd, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_sample"}, sample_out, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic reset_mid_read();
        pulse();
        @(negedge clk); audio_tick = 1;
        @(negedge clk); audio_tick = 0;
        chk("pre_reset_rd", rom_rd, 1);
        reset_n = 0;
        #1 check_reset_outputs("mid_reset");
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_valid", sample_valid, 0);
        end
        reset_n = 1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[0] = 1000;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;

        gain = 1023;
        pulse();
        do_tick();
        chk("unity_pos", sample_out, 999);
        rom[0] = -1000;
        pulse();
        do_tick();
        chk("unity_neg", sample_out, -1000);
        gain = 0;
        pulse();
        do_tick();
        chk("gain_zero", sample_out, 0);

        pulse();
        repeat (6) begin
            gain = 10'($urandom);
            do_tick();
        end
        chk("end_idle_busy", busy, 0);

        pulse();
        do_tick();
        do_tick();
        do_tick(0, 1);
        do_tick();
        chk("retrig_busy", busy, 1);
        repeat (4) do_tick();
        do_tick(1);
        chk("same_cycle_busy", busy, 1);

        do_tick(0, 0, 1);
        reset_mid_read();
        do_tick();
        chk("post_reset_zero", sample_out, 0);

        repeat (60) begin
            gain = 10'($urandom);
            rom[$urandom_range(0, LEN - 1)] = 16'($urandom);
            case ($urandom_range(0, 5))
                0: begin pulse(); do_tick(); end
                1: do_tick(1);
                2: do_tick(0, 1);
                3: do_tick(0, 0, 1);
                default: do_tick();
            endcase
        end

`ifdef DRUM_PLAYER_SMOOTH_EN
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        model_reset();
        for (int i = 0; i < LEN; i++) rom[i] = 1024;
        gain = 100;
        pulse();
        for (int k = 1; k <= 13; k++) begin
            do_tick(0, 1);
            chk("smooth_ramp", sample_out, (8 * k < 100) ? 8 * k : 100);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
